mem_rw_initiator: RTL and testbench

//  Requester-side master for the byte-wide memory R/W target. Takes one command at a time from a

---
 rtl/mem_rw_initiator_if.sv | 67 ++++++
 rtl/mem_rw_initiator.sv | 253 +++++++++++++++++++++++++
 tb/tb_mem_rw_initiator.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rw_initiator_if.sv
// ============================================================================
// Module   : mem_rw_initiator_if
// Purpose  : Bundles the host command/data channels and the memory R/W target
//            channels seen by mem_rw_initiator. Signal names keep the
//            initiator's point of view (i_* driven toward it, o_* driven by it).
// Modports : master - the initiator (drives o_*, reads i_*)
//            slave  - host logic plus target (drives i_*, reads o_*)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_rw_initiator_if;
  // host command channel
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic       i_cmd_rw;
  logic [5:0] i_cmd_addr;
  logic [3:0] i_cmd_num_b;
  // host write/read byte channels
  logic [7:0] i_hwr_data;
  logic       i_hwr_valid;
  logic       o_hwr_ready;
  logic [7:0] o_hrd_data;
  logic       o_hrd_valid;
  // completion
  logic       o_cmd_done;
  logic       o_cmd_err;
  logic [2:0] o_cmd_err_code;
  // target write request/data
  logic       o_wr_req;
  logic       i_wr_ack;
  logic [5:0] o_wr_addr;
  logic [3:0] o_wr_num_b;
  logic [7:0] o_wr_data;
  logic       o_wr_valid;
  logic       i_wr_done;
  // target read request/data
  logic       o_rd_req;
  logic       i_rd_ack;
  logic [5:0] o_rd_addr;
  logic [3:0] o_rd_num_b;
  logic [7:0] i_rd_data;
  logic       i_rd_valid;
  logic       o_rd_done;
  // target error report
  logic       i_err;
  logic [2:0] i_err_code;
  logic       o_err_ack;

  modport master (
    input  i_cmd_valid, i_cmd_rw, i_cmd_addr, i_cmd_num_b, i_hwr_data, i_hwr_valid,
           i_wr_ack, i_wr_done, i_rd_ack, i_rd_data, i_rd_valid, i_err, i_err_code,
    output o_cmd_ready, o_hwr_ready, o_hrd_data, o_hrd_valid, o_cmd_done, o_cmd_err,
           o_cmd_err_code, o_wr_req, o_wr_addr, o_wr_num_b, o_wr_data, o_wr_valid,
           o_rd_req, o_rd_addr, o_rd_num_b, o_rd_done, o_err_ack
  );

  modport slave (
    output i_cmd_valid, i_cmd_rw, i_cmd_addr, i_cmd_num_b, i_hwr_data, i_hwr_valid,
           i_wr_ack, i_wr_done, i_rd_ack, i_rd_data, i_rd_valid, i_err, i_err_code,
    input  o_cmd_ready, o_hwr_ready, o_hrd_data, o_hrd_valid, o_cmd_done, o_cmd_err,
           o_cmd_err_code, o_wr_req, o_wr_addr, o_wr_num_b, o_wr_data, o_wr_valid,
           o_rd_req, o_rd_addr, o_rd_num_b, o_rd_done, o_err_ack
  );
endinterface

`default_nettype wire

// File: rtl/mem_rw_initiator.sv
// ============================================================================
// Module   : mem_rw_initiator
// Purpose  : Requester-side master for a byte-wide memory R/W target. Accepts
//            one host command at a time, runs the request/ack handshake and
//            the per-byte data handshakes, and reports completion with the
//            target error code or a local timeout (code 3'b111).
// Ports    : i_clk   - clock, rising edge
//            i_reset - asynchronous active-low reset
//            bus     - mem_rw_initiator_if.master (host + target channels)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rw_initiator #(
  parameter int TIMEOUT_CYC = 32
) (
  input  wire logic           i_clk,
  input  wire logic           i_reset,
  mem_rw_initiator_if.master  bus
);

  localparam logic [5:0] TIMER_LAST = 6'(TIMEOUT_CYC - 1);
  localparam logic [2:0] CODE_TIMEOUT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WREQ = 3'd1, S_WDAT = 3'd2, S_RREQ = 3'd3,
    S_RDAT = 3'd4, S_ERR  = 3'd5, S_DONE = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] num_b_q, num_b_d;
  logic [3:0] loaded_q, loaded_d;     // host bytes taken into o_wr_data
  logic [3:0] xfer_q, xfer_d;         // bytes sent (write) or received (read)
  logic [5:0] timer_q, timer_d;
  logic [2:0] err_code_q, err_code_d;
  logic       wr_req_q, wr_req_d, wr_valid_q, wr_valid_d;
  logic [5:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [3:0] wr_num_b_q, wr_num_b_d, rd_num_b_q, rd_num_b_d;
  logic [7:0] wr_data_q, wr_data_d, hrd_data_q, hrd_data_d;
  logic       rd_req_q, rd_req_d, rd_done_q, rd_done_d, hrd_valid_q, hrd_valid_d;
  logic       cmd_done_q, cmd_done_d, cmd_err_q, cmd_err_d, err_ack_q, err_ack_d;
  logic [2:0] cmd_err_code_q, cmd_err_code_d;

  logic w_hwr_ready, w_timeout, w_abort_err, w_abort_to;

  assign w_hwr_ready = (state_q == S_WDAT) && !wr_valid_q && (loaded_q < num_b_q);
  assign w_timeout   = (timer_q == TIMER_LAST);

  always_comb begin
    state_d        = state_q;
    num_b_d        = num_b_q;
    loaded_d       = loaded_q;
    xfer_d         = xfer_q;
    timer_d        = '0;   // any cycle that does not count clears the timer
    err_code_d     = err_code_q;
    wr_req_d       = wr_req_q;
    wr_addr_d      = wr_addr_q;
    wr_num_b_d     = wr_num_b_q;
    wr_data_d      = wr_data_q;
    wr_valid_d     = wr_valid_q;
    rd_req_d       = rd_req_q;
    rd_addr_d      = rd_addr_q;
    rd_num_b_d     = rd_num_b_q;
    rd_done_d      = rd_done_q;
    hrd_data_d     = hrd_data_q;
    hrd_valid_d    = 1'b0;
    cmd_done_d     = 1'b0;
    cmd_err_d      = cmd_err_q;
    cmd_err_code_d = cmd_err_code_q;
    err_ack_d      = err_ack_q;
    w_abort_err    = 1'b0;
    w_abort_to     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          num_b_d        = bus.i_cmd_num_b;
          loaded_d       = '0;
          xfer_d         = '0;
          cmd_err_d      = 1'b0;
          cmd_err_code_d = '0;
          if (bus.i_cmd_num_b == 4'd0) begin
            state_d    = S_DONE;
            cmd_done_d = 1'b1;
          end else if (bus.i_cmd_rw) begin
            state_d    = S_WREQ;
            wr_req_d   = 1'b1;
            wr_addr_d  = bus.i_cmd_addr;
            wr_num_b_d = bus.i_cmd_num_b;
          end else begin
            state_d    = S_RREQ;
            rd_req_d   = 1'b1;
            rd_addr_d  = bus.i_cmd_addr;
            rd_num_b_d = bus.i_cmd_num_b;
          end
        end
      end
      S_WREQ: begin
        if (bus.i_err)           w_abort_err = 1'b1;
        else if (bus.i_wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = S_WDAT;
        end
        else if (w_timeout)      w_abort_to = 1'b1;
        else                     timer_d = timer_q + 6'd1;
      end
      S_WDAT: begin
        if (bus.i_err) begin
          w_abort_err = 1'b1;
        end else if (wr_valid_q) begin
          if (bus.i_wr_done) begin
            wr_valid_d = 1'b0;
            xfer_d     = xfer_q + 4'd1;
            if (xfer_q + 4'd1 == num_b_q) begin
              state_d    = S_DONE;
              cmd_done_d = 1'b1;
            end
          end
          else if (w_timeout) w_abort_to = 1'b1;
          else                timer_d = timer_q + 6'd1;
        end else if (bus.i_hwr_valid && w_hwr_ready) begin
          wr_data_d  = bus.i_hwr_data;
          wr_valid_d = 1'b1;
          loaded_d   = loaded_q + 4'd1;
        end
      end
      S_RREQ: begin
        if (bus.i_err)           w_abort_err = 1'b1;
        else if (bus.i_rd_ack) begin
          rd_req_d  = 1'b0;
          rd_done_d = 1'b1;   // held high for the whole data phase
          state_d   = S_RDAT;
        end
        else if (w_timeout)      w_abort_to = 1'b1;
        else                     timer_d = timer_q + 6'd1;
      end
      S_RDAT: begin
        if (bus.i_err) begin
          w_abort_err = 1'b1;
        end else if (bus.i_rd_valid) begin
          hrd_data_d  = bus.i_rd_data;
          hrd_valid_d = 1'b1;
          xfer_d      = xfer_q + 4'd1;
          if (xfer_q + 4'd1 == num_b_q) begin
            rd_done_d  = 1'b0;
            state_d    = S_DONE;
            cmd_done_d = 1'b1;
          end
        end
        else if (w_timeout) w_abort_to = 1'b1;
        else                timer_d = timer_q + 6'd1;
      end
      S_ERR: begin
        if (!bus.i_err) begin
          err_ack_d      = 1'b0;
          state_d        = S_DONE;
          cmd_done_d     = 1'b1;
          cmd_err_d      = 1'b1;
          cmd_err_code_d = err_code_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Both abort paths release every target-facing strobe in the same cycle.
    if (w_abort_err || w_abort_to) begin
      wr_req_d   = 1'b0;
      wr_valid_d = 1'b0;
      rd_req_d   = 1'b0;
      rd_done_d  = 1'b0;
    end
    if (w_abort_err) begin
      state_d    = S_ERR;
      err_code_d = bus.i_err_code;
      err_ack_d  = 1'b1;
    end else if (w_abort_to) begin
      state_d        = S_DONE;
      cmd_done_d     = 1'b1;
      cmd_err_d      = 1'b1;
      cmd_err_code_d = CODE_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q        <= S_IDLE;
      num_b_q        <= '0;
      loaded_q       <= '0;
      xfer_q         <= '0;
      timer_q        <= '0;
      err_code_q     <= '0;
      wr_req_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_num_b_q     <= '0;
      wr_data_q      <= '0;
      wr_valid_q     <= 1'b0;
      rd_req_q       <= 1'b0;
      rd_addr_q      <= '0;
      rd_num_b_q     <= '0;
      rd_done_q      <= 1'b0;
      hrd_data_q     <= '0;
      hrd_valid_q    <= 1'b0;
      cmd_done_q     <= 1'b0;
      cmd_err_q      <= 1'b0;
      cmd_err_code_q <= '0;
      err_ack_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      num_b_q        <= num_b_d;
      loaded_q       <= loaded_d;
      xfer_q         <= xfer_d;
      timer_q        <= timer_d;
      err_code_q     <= err_code_d;
      wr_req_q       <= wr_req_d;
      wr_addr_q      <= wr_addr_d;
      wr_num_b_q     <= wr_num_b_d;
      wr_data_q      <= wr_data_d;
      wr_valid_q     <= wr_valid_d;
      rd_req_q       <= rd_req_d;
      rd_addr_q      <= rd_addr_d;
      rd_num_b_q     <= rd_num_b_d;
      rd_done_q      <= rd_done_d;
      hrd_data_q     <= hrd_data_d;
      hrd_valid_q    <= hrd_valid_d;
      cmd_done_q     <= cmd_done_d;
      cmd_err_q      <= cmd_err_d;
      cmd_err_code_q <= cmd_err_code_d;
      err_ack_q      <= err_ack_d;
    end
  end

  assign bus.o_cmd_ready    = (state_q == S_IDLE);
  assign bus.o_hwr_ready    = w_hwr_ready;
  assign bus.o_hrd_data     = hrd_data_q;
  assign bus.o_hrd_valid    = hrd_valid_q;
  assign bus.o_cmd_done     = cmd_done_q;
  assign bus.o_cmd_err      = cmd_err_q;
  assign bus.o_cmd_err_code = cmd_err_code_q;
  assign bus.o_wr_req       = wr_req_q;
  assign bus.o_wr_addr      = wr_addr_q;
  assign bus.o_wr_num_b     = wr_num_b_q;
  assign bus.o_wr_data      = wr_data_q;
  assign bus.o_wr_valid     = wr_valid_q;
  assign bus.o_rd_req       = rd_req_q;
  assign bus.o_rd_addr      = rd_addr_q;
  assign bus.o_rd_num_b     = rd_num_b_q;
  assign bus.o_rd_done      = rd_done_q;
  assign bus.o_err_ack      = err_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_rw_initiator.sv
// ============================================================================
// Module   : tb_mem_rw_initiator
// Purpose  : Directed self-checking bench for mem_rw_initiator: write, read,
//            target error, request timeout, zero-length command, host stall
//            in the write data phase, and reset during a read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_rw_initiator;

  localparam int TIMEOUT_CYC = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] hbytes [0:15];
  logic [7:0] beat_data [0:15];

  mem_rw_initiator_if bus ();

  mem_rw_initiator #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [5:0] addr, input logic [3:0] n);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_rw    = rw;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_num_b = n;
    step;
    bus.i_cmd_valid = 1'b0;
  endtask

  // Host + target model for the write data phase. The target completes every
  // valid byte immediately; when err_after equals the number of completed
  // bytes it raises i_err (code 010) together with i_wr_done instead.
  task automatic do_wdat(input int n, input int err_after,
                         output int nbeats, output bit done_seen, output bit ack_seen);
    int  hidx;
    bit  acc;
    hidx = 0; nbeats = 0; done_seen = 0; ack_seen = 0;
    for (int c = 0; c < 80; c++) begin
      bus.i_hwr_valid = (hidx < n);
      bus.i_hwr_data  = hbytes[hidx[3:0]];
      acc = bus.i_hwr_valid && bus.o_hwr_ready;
      bus.i_wr_done = 1'b0;
      bus.i_err     = 1'b0;
      if (bus.o_wr_valid) begin
        bus.i_wr_done = 1'b1;
        if (nbeats == err_after) begin
          bus.i_err      = 1'b1;
          bus.i_err_code = 3'b010;
        end else begin
          beat_data[nbeats[3:0]] = bus.o_wr_data;
          nbeats++;
        end
      end
      step;
      if (acc) hidx++;
      if (bus.o_cmd_done) begin done_seen = 1; break; end
      if (bus.o_err_ack)  begin ack_seen = 1; break; end
    end
    bus.i_hwr_valid = 1'b0;
    bus.i_wr_done   = 1'b0;
  endtask

  int  nb;
  bit  dn, ak;
  int  cnt;
  bit  early_done;

  initial begin
    rst_n = 1'b0;
    bus.i_cmd_valid = 0; bus.i_cmd_rw = 0; bus.i_cmd_addr = 0; bus.i_cmd_num_b = 0;
    bus.i_hwr_data = 0; bus.i_hwr_valid = 0; bus.i_wr_ack = 0; bus.i_wr_done = 0;
    bus.i_rd_ack = 0; bus.i_rd_data = 0; bus.i_rd_valid = 0; bus.i_err = 0; bus.i_err_code = 0;
    hbytes[0] = 8'hA1; hbytes[1] = 8'hB2; hbytes[2] = 8'hC3; hbytes[3] = 8'hD4;
    for (int i = 4; i < 16; i++) hbytes[i] = 8'h00;
    for (int i = 0; i < 16; i++) beat_data[i] = 8'h00;
    step; step;
    rst_n = 1'b1;
    step;

    // ---- reset state
    chk("rst_cmd_ready", bus.o_cmd_ready, 1);
    chk("rst_wr_req",    bus.o_wr_req, 0);
    chk("rst_rd_req",    bus.o_rd_req, 0);
    chk("rst_cmd_done",  bus.o_cmd_done, 0);
    chk("rst_err_ack",   bus.o_err_ack, 0);

    // ---- write 3 bytes to 0x05, ack after 2 cycles
    issue(1'b1, 6'h05, 4'd3);
    chk("w1_req",       bus.o_wr_req, 1);
    chk("w1_addr",      bus.o_wr_addr, 6'h05);
    chk("w1_num_b",     bus.o_wr_num_b, 4'd3);
    chk("w1_cmd_ready", bus.o_cmd_ready, 0);
    step; step;
    chk("w1_req_held",  bus.o_wr_req, 1);
    bus.i_wr_ack = 1'b1;
    step;
    bus.i_wr_ack = 1'b0;
    chk("w1_req_drop",  bus.o_wr_req, 0);
    do_wdat(3, -1, nb, dn, ak);
    chk("w1_beats",     nb, 3);
    chk("w1_beat0",     beat_data[0], 8'hA1);
    chk("w1_beat1",     beat_data[1], 8'hB2);
    chk("w1_beat2",     beat_data[2], 8'hC3);
    chk("w1_done",      dn, 1);
    chk("w1_err",       bus.o_cmd_err, 0);
    step;
    chk("w1_done_pulse", bus.o_cmd_done, 0);
    chk("w1_idle",       bus.o_cmd_ready, 1);

    // ---- read 2 bytes from 0x3F
    issue(1'b0, 6'h3F, 4'd2);
    chk("r1_req",      bus.o_rd_req, 1);
    chk("r1_addr",     bus.o_rd_addr, 6'h3F);
    chk("r1_num_b",    bus.o_rd_num_b, 4'd2);
    bus.i_rd_ack = 1'b1;
    step;
    bus.i_rd_ack = 1'b0;
    chk("r1_req_drop", bus.o_rd_req, 0);
    chk("r1_rd_done",  bus.o_rd_done, 1);
    bus.i_rd_data = 8'h5A; bus.i_rd_valid = 1'b1;
    step;
    bus.i_rd_valid = 1'b0;
    chk("r1_hv0",      bus.o_hrd_valid, 1);
    chk("r1_hd0",      bus.o_hrd_data, 8'h5A);
    step;
    chk("r1_hv_pulse", bus.o_hrd_valid, 0);
    chk("r1_rd_done_mid", bus.o_rd_done, 1);
    bus.i_rd_data = 8'hA5; bus.i_rd_valid = 1'b1;
    step;
    bus.i_rd_valid = 1'b0;
    chk("r1_hv1",      bus.o_hrd_valid, 1);
    chk("r1_hd1",      bus.o_hrd_data, 8'hA5);
    chk("r1_rd_done_low", bus.o_rd_done, 0);
    chk("r1_done",     bus.o_cmd_done, 1);
    chk("r1_err",      bus.o_cmd_err, 0);
    step;
    chk("r1_done_pulse", bus.o_cmd_done, 0);
    chk("r1_hv_end",     bus.o_hrd_valid, 0);

    // ---- write 4 bytes, target error raised alongside the third byte's done
    issue(1'b1, 6'h10, 4'd4);
    bus.i_wr_ack = 1'b1;
    step;
    bus.i_wr_ack = 1'b0;
    do_wdat(4, 2, nb, dn, ak);
    chk("e1_sent",     nb, 2);
    chk("e1_ack_seen", ak, 1);
    chk("e1_wr_valid", bus.o_wr_valid, 0);
    step; step;
    chk("e1_ack_hold", bus.o_err_ack, 1);
    chk("e1_no_done",  bus.o_cmd_done, 0);
    bus.i_err = 1'b0;
    step;
    chk("e1_done",     bus.o_cmd_done, 1);
    chk("e1_err",      bus.o_cmd_err, 1);
    chk("e1_code",     bus.o_cmd_err_code, 3'b010);
    chk("e1_ack_drop", bus.o_err_ack, 0);
    step;
    chk("e1_err_hold", bus.o_cmd_err, 1);
    chk("e1_code_hold", bus.o_cmd_err_code, 3'b010);

    // ---- read request never acknowledged
    issue(1'b0, 6'h21, 4'd1);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!bus.o_rd_req) break;
      cnt++;
      step;
    end
    chk("t1_req_cycles", cnt, TIMEOUT_CYC);
    chk("t1_done",       bus.o_cmd_done, 1);
    chk("t1_err",        bus.o_cmd_err, 1);
    chk("t1_code",       bus.o_cmd_err_code, 3'b111);
    step;

    // ---- zero-length write
    issue(1'b1, 6'h07, 4'd0);
    chk("z1_no_req",  bus.o_wr_req, 0);
    chk("z1_done",    bus.o_cmd_done, 1);
    chk("z1_err",     bus.o_cmd_err, 0);
    chk("z1_code",    bus.o_cmd_err_code, 3'b000);
    step;
    chk("z1_idle",    bus.o_cmd_ready, 1);

    // ---- host stalls in the write data phase well past the timeout
    issue(1'b1, 6'h02, 4'd1);
    bus.i_wr_ack = 1'b1;
    step;
    bus.i_wr_ack = 1'b0;
    early_done = 0;
    for (int c = 0; c < 2 * TIMEOUT_CYC; c++) begin
      if (bus.o_cmd_done) early_done = 1;
      step;
    end
    chk("s1_no_timeout", early_done, 0);
    chk("s1_busy",       bus.o_cmd_ready, 0);
    chk("s1_hwr_ready",  bus.o_hwr_ready, 1);
    hbytes[0] = 8'h3C;
    do_wdat(1, -1, nb, dn, ak);
    chk("s1_beats",  nb, 1);
    chk("s1_data",   beat_data[0], 8'h3C);
    chk("s1_done",   dn, 1);
    chk("s1_err",    bus.o_cmd_err, 0);
    step;

    // ---- reset asserted while the first read byte is being delivered
    issue(1'b0, 6'h11, 4'd2);
    bus.i_rd_ack = 1'b1;
    step;
    bus.i_rd_ack = 1'b0;
    bus.i_rd_data = 8'h77; bus.i_rd_valid = 1'b1;
    step;
    bus.i_rd_valid = 1'b0;
    chk("x1_hv_before", bus.o_hrd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("x1_rd_done",  bus.o_rd_done, 0);
    chk("x1_hrd_valid", bus.o_hrd_valid, 0);
    chk("x1_hrd_data", bus.o_hrd_data, 8'h00);
    chk("x1_rd_addr",  bus.o_rd_addr, 6'h00);
    step;
    rst_n = 1'b1;
    step;
    chk("x1_cmd_ready", bus.o_cmd_ready, 1);
    chk("x1_rd_req",    bus.o_rd_req, 0);
    chk("x1_cmd_done",  bus.o_cmd_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
